// File: rtl/sokoban_pkg.sv
// Shared encodings between the PS/2 front end and the game core:
// direction one-hots, scan codes and the key-to-direction map.
package sokoban_pkg;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  typedef enum logic [1:0] {
    S_IDLE,
    S_E0,
    S_F0,
    S_E0F0
  } dec_state_e;

  typedef enum logic {
    RX_IDLE,
    RX_RECV
  } rx_state_e;

  function automatic logic [3:0] key_dir(
    input logic [7:0] code,
    input logic       ext,
    input logic       wasd
  );
    logic [3:0] d;
    d = DIR_NONE;
    if (ext) begin
      case (code)
        SC_UP:    d = DIR_UP;
        SC_DOWN:  d = DIR_DOWN;
        SC_LEFT:  d = DIR_LEFT;
        SC_RIGHT: d = DIR_RIGHT;
        default:  d = DIR_NONE;
      endcase
    end else if (wasd) begin
      case (code)
        SC_W:    d = DIR_UP;
        SC_S:    d = DIR_DOWN;
        SC_A:    d = DIR_LEFT;
        SC_D:    d = DIR_RIGHT;
        default: d = DIR_NONE;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchroniser, falling-edge detect, shifter,
// odd-parity/stop check and an inter-edge watchdog.
module ps2_rx_frame
  import sokoban_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    sc_q, sc_d;
  logic [1:0]    sd_q, sd_d;
  rx_state_e     state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [8:0]    sh_q, sh_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic fall;
  logic din;

  assign fall = sc_q[2] & ~sc_q[1];
  assign din  = sd_q[1];

  always_comb begin
    sc_d    = {sc_q[1:0], ps2_clk};
    sd_d    = {sd_q[0], ps2_data};
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    wd_d    = wd_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (fall) begin
      wd_d = '0;
      unique case (state_q)
        RX_IDLE: begin
          if (!din) begin
            state_d = RX_RECV;
            cnt_d   = '0;
          end
        end
        RX_RECV: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd9) begin
            state_d = RX_IDLE;
            cnt_d   = '0;
            if ((^sh_q) && din) begin
              byte_d  = sh_q[7:0];
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            sh_d = {din, sh_q[8:1]};
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (state_q == RX_RECV) begin
      // a stalled keyboard would otherwise wedge the shifter mid-byte
      if (wd_q == WD_LAST) begin
        wd_d    = '0;
        cnt_d   = '0;
        state_d = RX_IDLE;
        err_d   = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sc_q    <= 3'b111;
      sd_q    <= 2'b11;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      wd_q    <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sc_q    <= sc_d;
      sd_q    <= sd_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      wd_q    <= wd_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign rx_byte  = byte_q;
  assign rx_valid = valid_q;
  assign rx_err   = err_q;

endmodule

// File: rtl/ps2_dir_decoder.sv
// PS/2 keyboard to held one-hot direction level for the game core.
// Handles E0 extension and F0 break prefixes.
module ps2_dir_decoder
  import sokoban_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int ENABLE_WASD    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] dirMove,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (rx_err)
  );

  localparam logic WASD = (ENABLE_WASD != 0);

  dec_state_e state_q, state_d;
  logic [3:0] dir_q, dir_d;
  logic       ext;
  logic [3:0] map;

  assign ext = (state_q == S_E0) || (state_q == S_E0F0);
  assign map = key_dir(rx_byte, ext, WASD);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    if (rx_err) begin
      state_d = S_IDLE;
    end else if (rx_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_byte == SC_E0) begin
            state_d = S_E0;
          end else if (rx_byte == SC_F0) begin
            state_d = S_F0;
          end else if (map != DIR_NONE) begin
            dir_d = map;
          end
        end
        S_E0: begin
          if (rx_byte == SC_F0) begin
            state_d = S_E0F0;
          end else begin
            state_d = S_IDLE;
            if (map != DIR_NONE) dir_d = map;
          end
        end
        S_F0, S_E0F0: begin
          state_d = S_IDLE;
          // releasing a key that is no longer the latest press is ignored
          if (map != DIR_NONE && dir_q == map) dir_d = DIR_NONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_NONE;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  end

  assign dirMove    = dir_q;
  assign scan_code  = rx_byte;
  assign scan_valid = rx_valid;
  assign frame_err  = rx_err;

endmodule
